// File: rtl/sys_defs.sv
// Shared types for the multi-slot commit stage: ROB head entries, commit packets,
// memory sizes and the store-handshake FSM states.
package sys_defs;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'd0,
        MEM_HALF   = 2'd1,
        MEM_WORD   = 2'd2,
        MEM_DOUBLE = 2'd3
    } MEM_SIZE;

    typedef struct packed {
        logic        valid;
        logic [31:0] value;
        logic [4:0]  dest_reg;
        logic [31:0] dest_addr;
        MEM_SIZE     mem_size;
        logic        is_store;
    } ROB_ENTRY;

    typedef struct packed {
        logic        valid;
        logic [31:0] data_out;
        logic [31:0] mem_address;
        MEM_SIZE     mem_size;
        logic        wr_mem;
        logic [4:0]  reg_wr_idx_out;
        logic        reg_wr_en_out;
    } COMMIT_PACKET;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } commit_state_e;

endpackage

// File: rtl/commit_select.sv
// Combinational prefix scan over the ROB head: counts leading ready non-stores
// and flags a ready store sitting in slot 0.
module commit_select #(
    parameter int COMMIT_WIDTH = 2,
    parameter int CNTW         = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0] valid,
    input  logic [COMMIT_WIDTH-1:0] ready,
    input  logic [COMMIT_WIDTH-1:0] is_store,
    output logic [CNTW-1:0]         k,
    output logic                    store_at_head
);

    logic open;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        k    = '0;
        open = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (open && valid[i] && ready[i] && !is_store[i]) begin
                k = CNTW'(i + 1);
            end else begin
                open = 1'b0;
            end
        end
        store_at_head = valid[0] & ready[0] & is_store[0];
    end

endmodule

// File: rtl/multi_commit_stage.sv
// Retires up to COMMIT_WIDTH in-order ROB head entries per cycle and serialises
// stores through a req/ready/done handshake, stalling commit while one is in flight.
module multi_commit_stage
    import sys_defs::*;
#(
    parameter  int COMMIT_WIDTH = 2,
    parameter  int CNT_W        = 64,
    localparam int CNTW         = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  ROB_ENTRY     head_entries [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0] head_ready,
    output logic [CNTW-1:0]  rob_retire_cnt,
    output COMMIT_PACKET cmt_packets_out [COMMIT_WIDTH],
    output logic         mem_req_valid,
    output logic [31:0]  mem_req_addr,
    output logic [31:0]  mem_req_data,
    output MEM_SIZE      mem_req_size,
    input  logic         mem_req_ready,
    input  logic         mem_done,
    output logic [CNT_W-1:0] retired_count
);

    commit_state_e state;
    logic [COMMIT_WIDTH-1:0] slot_valid, slot_store;
    logic [CNTW-1:0] sel_k;
    logic store_at_head;
    logic store_commit;

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot_valid[i] = head_entries[i].valid;
            slot_store[i] = head_entries[i].is_store;
        end
    end

    commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .CNTW         (CNTW)
    ) u_select (
        .valid         (slot_valid),
        .ready         (head_ready),
        .is_store      (slot_store),
        .k             (sel_k),
        .store_at_head (store_at_head)
    );

    // A store retires in the cycle mem_done is seen after (or with) acceptance.
    assign store_commit = ((state == ST_REQ) && mem_req_ready && mem_done) ||
                          ((state == ST_WAIT) && mem_done);

    always_comb begin
        rob_retire_cnt = '0;
        if (!reset) begin
            if (state == IDLE)     rob_retire_cnt = sel_k;
            else if (store_commit) rob_retire_cnt = CNTW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_size  <= MEM_BYTE;
            retired_count <= '0;
            for (int i = 0; i < COMMIT_WIDTH; i++) cmt_packets_out[i] <= '0;
        end else begin
            retired_count <= retired_count + CNT_W'(rob_retire_cnt);
            for (int i = 0; i < COMMIT_WIDTH; i++) cmt_packets_out[i] <= '0;

            if (store_commit) begin
                cmt_packets_out[0].valid       <= 1'b1;
                cmt_packets_out[0].data_out    <= mem_req_data;
                cmt_packets_out[0].mem_address <= mem_req_addr;
                cmt_packets_out[0].mem_size    <= mem_req_size;
                cmt_packets_out[0].wr_mem      <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    for (int i = 0; i < COMMIT_WIDTH; i++) begin
                        if (CNTW'(i) < sel_k) begin
                            cmt_packets_out[i].valid          <= 1'b1;
                            cmt_packets_out[i].data_out       <= head_entries[i].value;
                            cmt_packets_out[i].mem_address    <= head_entries[i].dest_addr;
                            cmt_packets_out[i].mem_size       <= head_entries[i].mem_size;
                            cmt_packets_out[i].reg_wr_idx_out <= head_entries[i].dest_reg;
                            cmt_packets_out[i].reg_wr_en_out  <= (head_entries[i].dest_reg != ZERO_REG);
                        end
                    end
                    if (store_at_head) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= head_entries[0].dest_addr;
                        mem_req_data  <= head_entries[0].value;
                        mem_req_size  <= head_entries[0].mem_size;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= mem_done ? IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_commit_stage.sv
// Directed self-checking bench for multi_commit_stage with COMMIT_WIDTH=2.
module tb_multi_commit_stage;
    import sys_defs::*;

    logic         clock = 1'b0;
    logic         reset;
    ROB_ENTRY     head_entries [2];
    logic [1:0]   head_ready;
    logic [1:0]   rob_retire_cnt;
    COMMIT_PACKET pkts [2];
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_data;
    MEM_SIZE      mem_req_size;
    logic         mem_req_ready;
    logic         mem_done;
    logic [63:0]  retired_count;

    int checks = 0;
    int errors = 0;

    multi_commit_stage #(.COMMIT_WIDTH(2), .CNT_W(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .head_entries    (head_entries),
        .head_ready      (head_ready),
        .rob_retire_cnt  (rob_retire_cnt),
        .cmt_packets_out (pkts),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_size    (mem_req_size),
        .mem_req_ready   (mem_req_ready),
        .mem_done        (mem_done),
        .retired_count   (retired_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ROB_ENTRY mk(input logic v, input logic [31:0] val, input logic [4:0] dst,
                                    input logic [31:0] addr, input MEM_SIZE sz, input logic st);
        ROB_ENTRY e;
        e.valid = v; e.value = val; e.dest_reg = dst;
        e.dest_addr = addr; e.mem_size = sz; e.is_store = st;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_head();
        head_entries[0] = '0;
        head_entries[1] = '0;
        head_ready      = 2'b00;
    endtask

    initial begin
        reset = 1'b1; mem_req_ready = 1'b0; mem_done = 1'b0;
        clear_head();
        step(); step();
        check("rst_cnt", 64'(rob_retire_cnt), 64'd0);
        check("rst_retired", retired_count, 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_pkt0", 64'(pkts[0]), 64'd0);
        reset = 1'b0;

        // Both slots ready non-stores: full width retires.
        head_entries[0] = mk(1, 32'h11, 5'd5, 32'h40, MEM_WORD, 0);
        head_entries[1] = mk(1, 32'h22, 5'd0, 32'h44, MEM_HALF, 0);
        head_ready = 2'b11;
        #1 check("t1_cnt", 64'(rob_retire_cnt), 64'd2);
        step(); clear_head(); #1;
        check("t1_p0_valid", 64'(pkts[0].valid), 64'd1);
        check("t1_p0_wen", 64'(pkts[0].reg_wr_en_out), 64'd1);
        check("t1_p0_idx", 64'(pkts[0].reg_wr_idx_out), 64'd5);
        check("t1_p0_data", 64'(pkts[0].data_out), 64'h11);
        check("t1_p1_valid", 64'(pkts[1].valid), 64'd1);
        check("t1_p1_wen", 64'(pkts[1].reg_wr_en_out), 64'd0);
        check("t1_p1_size", 64'(pkts[1].mem_size), 64'(MEM_HALF));
        check("t1_retired", retired_count, 64'd2);

        // Non-ready slot 0 blocks a ready slot 1; mem_done in IDLE is ignored.
        head_entries[0] = mk(1, 32'h33, 5'd3, 32'h0, MEM_WORD, 0);
        head_entries[1] = mk(1, 32'h44, 5'd4, 32'h0, MEM_WORD, 0);
        head_ready = 2'b10; mem_done = 1'b1;
        #1 check("t2_cnt", 64'(rob_retire_cnt), 64'd0);
        step(); mem_done = 1'b0; #1;
        check("t2_p0_valid", 64'(pkts[0].valid), 64'd0);
        check("t2_p1_valid", 64'(pkts[1].valid), 64'd0);
        check("t2_retired", retired_count, 64'd2);

        // Store at head; ready after 3 request cycles, done 2 cycles later.
        head_entries[0] = mk(1, 32'hDEAD, 5'd9, 32'h100, MEM_WORD, 1);
        head_entries[1] = '0;
        head_ready = 2'b01;
        #1 check("t3_launch_cnt", 64'(rob_retire_cnt), 64'd0);
        step();
        head_entries[0] = mk(1, 32'hBEEF, 5'd6, 32'h200, MEM_BYTE, 0);
        head_entries[1] = mk(1, 32'hCAFE, 5'd7, 32'h204, MEM_BYTE, 0);
        head_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            mem_done      = (c == 0);
            mem_req_ready = (c == 2);
            #1;
            check($sformatf("t3_req_valid%0d", c), 64'(mem_req_valid), 64'd1);
            check($sformatf("t3_req_addr%0d", c), 64'(mem_req_addr), 64'h100);
            check($sformatf("t3_req_data%0d", c), 64'(mem_req_data), 64'hDEAD);
            check($sformatf("t3_req_size%0d", c), 64'(mem_req_size), 64'(MEM_WORD));
            check($sformatf("t3_req_cnt%0d", c), 64'(rob_retire_cnt), 64'd0);
            check($sformatf("t3_req_p0%0d", c), 64'(pkts[0].valid), 64'd0);
            step();
        end
        mem_req_ready = 1'b0; mem_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("t3_wait_valid%0d", c), 64'(mem_req_valid), 64'd0);
            check($sformatf("t3_wait_cnt%0d", c), 64'(rob_retire_cnt), 64'd0);
            step();
        end
        mem_done = 1'b1;
        #1 check("t3_done_cnt", 64'(rob_retire_cnt), 64'd1);
        step(); mem_done = 1'b0; clear_head(); #1;
        check("t3_p0_valid", 64'(pkts[0].valid), 64'd1);
        check("t3_p0_wr_mem", 64'(pkts[0].wr_mem), 64'd1);
        check("t3_p0_wen", 64'(pkts[0].reg_wr_en_out), 64'd0);
        check("t3_p0_addr", 64'(pkts[0].mem_address), 64'h100);
        check("t3_p0_data", 64'(pkts[0].data_out), 64'hDEAD);
        check("t3_p1_valid", 64'(pkts[1].valid), 64'd0);
        check("t3_retired", retired_count, 64'd3);

        // Non-store then store: one retires, store launches next cycle from slot 0.
        head_entries[0] = mk(1, 32'h77, 5'd7, 32'h0, MEM_WORD, 0);
        head_entries[1] = mk(1, 32'h55, 5'd1, 32'h300, MEM_HALF, 1);
        head_ready = 2'b11;
        #1 check("t4_cnt", 64'(rob_retire_cnt), 64'd1);
        step();
        head_entries[0] = head_entries[1];
        head_entries[1] = '0;
        head_ready = 2'b01;
        #1;
        check("t4_p0_idx", 64'(pkts[0].reg_wr_idx_out), 64'd7);
        check("t4_p1_valid", 64'(pkts[1].valid), 64'd0);
        check("t4_store_cnt", 64'(rob_retire_cnt), 64'd0);
        check("t4_req_idle", 64'(mem_req_valid), 64'd0);
        step(); clear_head(); #1;
        check("t4_req_valid", 64'(mem_req_valid), 64'd1);
        check("t4_req_addr", 64'(mem_req_addr), 64'h300);
        check("t4_retired", retired_count, 64'd4);

        // Reset while in ST_REQ abandons the store.
        reset = 1'b1;
        #1 check("t5_rst_cnt", 64'(rob_retire_cnt), 64'd0);
        step(); reset = 1'b0; #1;
        check("t5_req_valid", 64'(mem_req_valid), 64'd0);
        check("t5_retired", retired_count, 64'd0);
        check("t5_p0_valid", 64'(pkts[0].valid), 64'd0);
        head_entries[0] = mk(1, 32'h1, 5'd2, 32'h0, MEM_WORD, 0);
        head_ready = 2'b01;
        #1 check("t5_idle_cnt", 64'(rob_retire_cnt), 64'd1);
        step();

        // mem_req_ready and mem_done together commit the store immediately.
        head_entries[0] = mk(1, 32'h1234, 5'd3, 32'h500, MEM_BYTE, 1);
        head_ready = 2'b01;
        step(); clear_head();
        mem_req_ready = 1'b1; mem_done = 1'b1;
        #1 check("t6_cnt", 64'(rob_retire_cnt), 64'd1);
        step(); mem_req_ready = 1'b0; mem_done = 1'b0; #1;
        check("t6_p0_wr_mem", 64'(pkts[0].wr_mem), 64'd1);
        check("t6_p0_addr", 64'(pkts[0].mem_address), 64'h500);
        check("t6_p0_size", 64'(pkts[0].mem_size), 64'(MEM_BYTE));
        check("t6_req_valid", 64'(mem_req_valid), 64'd0);
        check("t6_retired", retired_count, 64'd2);
        head_entries[0] = mk(1, 32'h2, 5'd4, 32'h0, MEM_WORD, 0);
        head_ready = 2'b01;
        #1 check("t6_idle_cnt", 64'(rob_retire_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
